// File: rtl/alu_decode_unit_if.sv
// Execute-stage bus: operand/instruction inputs and registered results.
// Shared by alu_decode_unit (slave) and whatever drives it (master).
interface alu_decode_unit_if;
    logic        in_valid;
    logic [31:0] instruction;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic        out_valid;
    logic        reg_write;
    logic        alu_src;
    logic        mem_write;
    logic        mem_read;
    logic        mem_to_reg;
    logic [1:0]  alu_op;
    logic [31:0] alu_result;
    logic        zero;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        illegal;

    modport master (
        output in_valid, instruction, rs1_data, rs2_data, imm,
        input  out_valid, reg_write, alu_src, mem_write, mem_read,
        input  mem_to_reg, alu_op, alu_result, zero, store_data,
        input  rd, illegal
    );

    modport slave (
        input  in_valid, instruction, rs1_data, rs2_data, imm,
        output out_valid, reg_write, alu_src, mem_write, mem_read,
        output mem_to_reg, alu_op, alu_result, zero, store_data,
        output rd, illegal
    );
endinterface

// File: rtl/alu_decode_unit.sv
// RV32I execute stage: opcode control, ALU-op decode and 32-bit ALU, 1-cycle.
// Optional illegal-encoding detection when ALU_ILLEGAL_DETECT_EN is defined.
module alu_decode_unit (
    input logic              clk,
    input logic              rst,
    alu_decode_unit_if.slave bus
);
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        alt;
    logic        c_reg_write;
    logic        c_alu_src;
    logic        c_mem_write;
    logic        c_mem_read;
    logic        c_mem_to_reg;
    logic        c_known;
    logic [1:0]  c_alu_op;
    logic [3:0]  alu_ctrl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  shamt;
    logic [31:0] alu_y;
    logic [31:0] result;
    logic        bad;
    logic        unused_bits;

    assign opcode = bus.instruction[6:0];
    assign funct3 = bus.instruction[14:12];
    assign funct7 = bus.instruction[31:25];
    assign op_a   = bus.rs1_data;
    assign op_b   = c_alu_src ? bus.imm : bus.rs2_data;
    assign shamt  = op_b[4:0];

    // Bits not otherwise consumed by the decode.
    assign unused_bits = ^{bus.instruction[24:15], funct7, c_known};

`ifdef ALU_ILLEGAL_DETECT_EN
    assign alt = (funct7 == 7'b0100000);
`else
    assign alt = funct7[5];
`endif

    // Main controller: opcode to datapath strobes and ALUOp class.
    always_comb begin
        c_reg_write  = 1'b0;
        c_alu_src    = 1'b0;
        c_mem_write  = 1'b0;
        c_mem_read   = 1'b0;
        c_mem_to_reg = 1'b0;
        c_alu_op     = 2'b00;
        c_known      = 1'b1;
        unique case (1'b1)
            (opcode == OP_R): begin
                c_reg_write = 1'b1;
                c_alu_op    = 2'b10;
            end
            (opcode == OP_I): begin
                c_reg_write = 1'b1;
                c_alu_src   = 1'b1;
                c_alu_op    = 2'b11;
            end
            (opcode == OP_LOAD): begin
                c_reg_write  = 1'b1;
                c_alu_src    = 1'b1;
                c_mem_read   = 1'b1;
                c_mem_to_reg = 1'b1;
            end
            (opcode == OP_STORE): begin
                c_alu_src   = 1'b1;
                c_mem_write = 1'b1;
            end
            (opcode == OP_BR): begin
                c_alu_op = 2'b01;
            end
            default: c_known = 1'b0;
        endcase
    end

    // ALU-operation decode from ALUOp class and funct3/funct7.
    always_comb begin
        alu_ctrl = ALU_ADD;
        unique case (c_alu_op)
            2'b00: alu_ctrl = ALU_ADD;
            2'b01: alu_ctrl = ALU_SUB;
            default: begin
                unique case (funct3)
                    3'b000: alu_ctrl = (c_alu_op == 2'b10 && alt)
                                       ? ALU_SUB : ALU_ADD;
                    3'b001: alu_ctrl = ALU_SLL;
                    3'b010: alu_ctrl = ALU_SLT;
                    3'b011: alu_ctrl = ALU_SLTU;
                    3'b100: alu_ctrl = ALU_XOR;
                    3'b101: alu_ctrl = alt ? ALU_SRA : ALU_SRL;
                    3'b110: alu_ctrl = ALU_OR;
                    default: alu_ctrl = ALU_AND;
                endcase
            end
        endcase
    end

    // 32-bit integer ALU.
    always_comb begin
        alu_y = 32'd0;
        unique case (alu_ctrl)
            ALU_AND:  alu_y = op_a & op_b;
            ALU_OR:   alu_y = op_a | op_b;
            ALU_ADD:  alu_y = op_a + op_b;
            ALU_XOR:  alu_y = op_a ^ op_b;
            ALU_SLL:  alu_y = op_a << shamt;
            ALU_SRL:  alu_y = op_a >> shamt;
            ALU_SUB:  alu_y = op_a - op_b;
            ALU_SRA:  alu_y = $signed(op_a) >>> shamt;
            ALU_SLT:  alu_y = {31'd0, $signed(op_a) < $signed(op_b)};
            ALU_SLTU: alu_y = {31'd0, op_a < op_b};
            default:  alu_y = 32'd0;
        endcase
    end

`ifdef ALU_ILLEGAL_DETECT_EN
    // Flag reserved funct7/funct3 combinations and unknown opcodes.
    always_comb begin
        bad = 1'b0;
        unique case (1'b1)
            (opcode == OP_R):
                bad = !((funct7 == 7'b0000000) ||
                        (funct7 == 7'b0100000 &&
                         (funct3 == 3'b000 || funct3 == 3'b101)));
            (opcode == OP_I):
                bad = (funct3 == 3'b001 && funct7 != 7'b0000000) ||
                      (funct3 == 3'b101 && funct7 != 7'b0000000 &&
                       funct7 != 7'b0100000);
            default: bad = !c_known;
        endcase
    end
`else
    assign bad = 1'b0;
`endif

    assign result = bad ? 32'd0 : alu_y;

    // Output register: reset clears all, bubbles clear strobes only.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid  <= 1'b0;
            bus.reg_write  <= 1'b0;
            bus.alu_src    <= 1'b0;
            bus.mem_write  <= 1'b0;
            bus.mem_read   <= 1'b0;
            bus.mem_to_reg <= 1'b0;
            bus.alu_op     <= 2'b00;
            bus.alu_result <= 32'd0;
            bus.zero       <= 1'b0;
            bus.store_data <= 32'd0;
            bus.rd         <= 5'd0;
            bus.illegal    <= 1'b0;
        end else if (bus.in_valid) begin
            bus.out_valid  <= 1'b1;
            bus.reg_write  <= c_reg_write & ~bad;
            bus.alu_src    <= c_alu_src & ~bad;
            bus.mem_write  <= c_mem_write & ~bad;
            bus.mem_read   <= c_mem_read & ~bad;
            bus.mem_to_reg <= c_mem_to_reg & ~bad;
            bus.alu_op     <= c_alu_op;
            bus.alu_result <= result;
            bus.zero       <= (result == 32'd0);
            bus.store_data <= bus.rs2_data;
            bus.rd         <= bus.instruction[11:7];
            bus.illegal    <= bad;
        end else begin
            bus.out_valid  <= 1'b0;
            bus.reg_write  <= 1'b0;
            bus.alu_src    <= 1'b0;
            bus.mem_write  <= 1'b0;
            bus.mem_read   <= 1'b0;
            bus.mem_to_reg <= 1'b0;
            bus.alu_op     <= 2'b00;
            bus.illegal    <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_decode_unit.sv
// Randomized + directed bench for alu_decode_unit against a behavioural model.
// Model honours ALU_ILLEGAL_DETECT_EN the same way the build does.
module tb_alu_decode_unit;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    alu_decode_unit_if bus ();

    alu_decode_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic        e_valid, e_rw, e_src, e_mw, e_mr, e_m2r, e_zero, e_ill;
    logic [1:0]  e_op;
    logic [31:0] e_res, e_sd;
    logic [4:0]  e_rd;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [6:0] f7,
                                        input logic [2:0] f3,
                                        input logic [6:0] op);
        return {f7, 5'd2, 5'd1, f3, 5'd3, op};
    endfunction

    // Reference operation by funct3 with plain arithmetic.
    function automatic logic [31:0] ref_f3(input logic [2:0] f3,
                                           input logic alt, input logic is_r,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        logic signed [31:0] sa;
        sa = a;
        case (f3)
            3'd0: if (is_r && alt) return a - b; else return a + b;
            3'd1: return a << b[4:0];
            3'd2: return (sa < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: if (alt) return sa >>> b[4:0]; else return a >> b[4:0];
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    task automatic model_zero();
        {e_valid, e_rw, e_src, e_mw, e_mr, e_m2r, e_zero, e_ill} = '0;
        e_op = 2'd0; e_res = 32'd0; e_sd = 32'd0; e_rd = 5'd0;
    endtask

    task automatic model_step(input logic v, input logic [31:0] ins,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] im);
        logic [6:0] op, f7;
        logic [2:0] f3;
        logic alt, ill;
        if (!v) begin
            {e_valid, e_rw, e_src, e_mw, e_mr, e_m2r, e_ill} = '0;
            e_op = 2'd0;
            return;
        end
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
`ifdef ALU_ILLEGAL_DETECT_EN
        alt = (f7 == 7'h20);
`else
        alt = f7[5];
`endif
        {e_rw, e_src, e_mw, e_mr, e_m2r} = '0;
        e_op = 2'd0; ill = 1'b0;
        case (op)
            7'h33: begin
                e_rw = 1; e_op = 2'd2; e_res = ref_f3(f3, alt, 1'b1, a, b);
                ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)));
            end
            7'h13: begin
                e_rw = 1; e_src = 1; e_op = 2'd3;
                e_res = ref_f3(f3, alt, 1'b0, a, im);
                ill = (f3 == 1 && f7 != 0) ||
                      (f3 == 5 && f7 != 0 && f7 != 7'h20);
            end
            7'h03: begin
                e_rw = 1; e_src = 1; e_mr = 1; e_m2r = 1; e_res = a + im;
            end
            7'h23: begin
                e_src = 1; e_mw = 1; e_res = a + im;
            end
            7'h63: begin
                e_op = 2'd1; e_res = a - b;
            end
            default: begin
                e_res = a + b; ill = 1'b1;
            end
        endcase
`ifdef ALU_ILLEGAL_DETECT_EN
        if (ill) begin
            {e_rw, e_src, e_mw, e_mr, e_m2r} = '0;
            e_res = 32'd0;
        end
        e_ill = ill;
`else
        e_ill = 1'b0;
`endif
        e_valid = 1'b1;
        e_zero = (e_res == 32'd0);
        e_sd = b;
        e_rd = ins[11:7];
    endtask

    task automatic compare_all(input string t);
        check({t, ".out_valid"}, 32'(bus.out_valid), 32'(e_valid));
        check({t, ".reg_write"}, 32'(bus.reg_write), 32'(e_rw));
        check({t, ".alu_src"}, 32'(bus.alu_src), 32'(e_src));
        check({t, ".mem_write"}, 32'(bus.mem_write), 32'(e_mw));
        check({t, ".mem_read"}, 32'(bus.mem_read), 32'(e_mr));
        check({t, ".mem_to_reg"}, 32'(bus.mem_to_reg), 32'(e_m2r));
        check({t, ".alu_op"}, 32'(bus.alu_op), 32'(e_op));
        check({t, ".alu_result"}, bus.alu_result, e_res);
        check({t, ".zero"}, 32'(bus.zero), 32'(e_zero));
        check({t, ".store_data"}, bus.store_data, e_sd);
        check({t, ".rd"}, 32'(bus.rd), 32'(e_rd));
        check({t, ".illegal"}, 32'(bus.illegal), 32'(e_ill));
    endtask

    task automatic issue(input string t, input logic v,
                         input logic [31:0] ins, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] im);
        bus.in_valid = v; bus.instruction = ins;
        bus.rs1_data = a; bus.rs2_data = b; bus.imm = im;
        if (rst) model_zero(); else model_step(v, ins, a, b, im);
        @(posedge clk);
        #1;
        compare_all(t);
    endtask

    task automatic rand_issue(input string t, input logic v);
        logic [6:0] op, f7;
        logic [31:0] ins, a, b, im;
        case ($urandom_range(0, 5))
            0: op = 7'h33; 1: op = 7'h13; 2: op = 7'h03;
            3: op = 7'h23; 4: op = 7'h63; default: op = 7'($urandom);
        endcase
        case ($urandom_range(0, 3))
            0, 1: f7 = 7'h00; 2: f7 = 7'h20; default: f7 = 7'($urandom);
        endcase
        ins = {f7, 10'($urandom), 3'($urandom), 5'($urandom), op};
        a = $urandom;
        b = ($urandom_range(0, 4) == 0) ? a : $urandom;
        im = ($urandom_range(0, 1) == 0) ? {{20{ins[31]}}, ins[31:20]}
                                          : $urandom;
        issue(t, v, ins, a, b, im);
    endtask

    initial begin
        bus.in_valid = 0; bus.instruction = 0;
        bus.rs1_data = 0; bus.rs2_data = 0; bus.imm = 0;
        model_zero();
        rst = 1'b1;
        rand_issue("rst0", 1'b1);
        rand_issue("rst1", 1'b1);
        rst = 1'b0;
        issue("rel", 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);

        issue("sub", 1'b1, enc(7'h20, 3'd0, 7'h33), 32'd5, 32'd5, 32'd9);
        check("sub_res", bus.alu_result, 32'd0);
        check("sub_zero", 32'(bus.zero), 32'd1);
        check("sub_op", 32'(bus.alu_op), 32'd2);

        issue("srai", 1'b1, enc(7'h20, 3'd5, 7'h13), 32'h8000_0000,
              32'd0, 32'h0000_0404);
        check("srai_res", bus.alu_result, 32'hF800_0000);
        issue("srli", 1'b1, enc(7'h00, 3'd5, 7'h13), 32'h8000_0000,
              32'd0, 32'h0000_0004);
        check("srli_res", bus.alu_result, 32'h0800_0000);

        issue("load", 1'b1, enc(7'h7F, 3'd2, 7'h03), 32'h100, 32'd0,
              32'hFFFF_FFFC);
        check("load_res", bus.alu_result, 32'h0000_00FC);
        issue("store", 1'b1, enc(7'h00, 3'd2, 7'h23), 32'h200,
              32'hDEAD_BEEF, 32'd8);
        check("store_sd", bus.store_data, 32'hDEAD_BEEF);

        issue("slt", 1'b1, enc(7'h00, 3'd2, 7'h33), 32'hFFFF_FFFF,
              32'd1, 32'd0);
        check("slt_res", bus.alu_result, 32'd1);
        issue("sltu", 1'b1, enc(7'h00, 3'd3, 7'h33), 32'hFFFF_FFFF,
              32'd1, 32'd0);
        check("sltu_res", bus.alu_result, 32'd0);
        issue("br", 1'b1, enc(7'h00, 3'd0, 7'h63), 32'd7, 32'd7, 32'd64);
        check("br_zero", 32'(bus.zero), 32'd1);

        for (int i = 0; i < 4; i++) rand_issue("b2b", 1'b1);
        issue("gap", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd2, 32'd3);

        issue("unk", 1'b1, enc(7'h00, 3'd0, 7'h7F), 32'd3, 32'd4, 32'd0);
`ifdef ALU_ILLEGAL_DETECT_EN
        check("unk_ill", 32'(bus.illegal), 32'd1);
`else
        check("unk_ill", 32'(bus.illegal), 32'd0);
`endif
        check("unk_rw", 32'(bus.reg_write), 32'd0);

        rst = 1'b1;
        rand_issue("rst_mid", 1'b1);
        rst = 1'b0;

        for (int i = 0; i < 500; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            rand_issue("rnd", $urandom_range(0, 4) != 0);
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
